// File: rtl/config_sequencer_if.sv
// Signal bundle between the host queue, RX_DECODER handshake and the sensor
// two-wire pins of config_sequencer.
interface config_sequencer_if #(
    parameter int WORD_W     = 16,
    parameter int FIFO_DEPTH = 4
);
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

    logic              ENABLE;
    logic              CONFIG_EN;
    logic [WORD_W-1:0] WORD_DATA;
    logic              WORD_VALID;
    logic              WORD_READY;
    logic              CONFIG_DONE;
    logic              CFG_SCL;
    logic              CFG_SDA;
    logic              CFG_OE;
    logic              BUSY;
    logic [LVL_W-1:0]  FIFO_LEVEL;
    logic [15:0]       WORDS_SENT;

    modport master (
        output ENABLE, CONFIG_EN, WORD_DATA, WORD_VALID,
        input  WORD_READY, CONFIG_DONE, CFG_SCL, CFG_SDA, CFG_OE, BUSY,
               FIFO_LEVEL, WORDS_SENT
    );

    modport slave (
        input  ENABLE, CONFIG_EN, WORD_DATA, WORD_VALID,
        output WORD_READY, CONFIG_DONE, CFG_SCL, CFG_SDA, CFG_OE, BUSY,
               FIFO_LEVEL, WORDS_SENT
    );
endinterface

// File: rtl/config_sequencer.sv
// Queues host configuration words and shifts one out, MSB first, on the
// two-wire sensor bus for every configuration window opened by RX_DECODER.
module config_sequencer #(
    parameter int WORD_W     = 16,
    parameter int CLK_DIV    = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               CLOCK,
    input  logic               RESET_N,
    config_sequencer_if.slave  bus
);
    localparam int HALF  = CLK_DIV / 2;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam int BIT_W = $clog2(WORD_W);
    localparam int DIV_W = $clog2(HALF + 1);

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT_LO, SHIFT_HI, DONE} state_t;

    state_t             state;
    logic               cfg_q;
    logic               had_word;
    logic [WORD_W-1:0]  shreg;
    logic [BIT_W-1:0]   bit_cnt;
    logic [DIV_W-1:0]   div_cnt;

    logic [WORD_W-1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [LVL_W-1:0]   level, lvl_nxt;

    logic               cfg_rise, push, pop, sent_inc;

    assign cfg_rise = bus.CONFIG_EN && !cfg_q;
    assign push     = bus.WORD_VALID && bus.WORD_READY;
    assign pop      = (state == LOAD);
    assign sent_inc = (state == DONE) && had_word;

    assign bus.FIFO_LEVEL = level;
    assign bus.BUSY       = (state != IDLE);

    // ---------------------------------------------------------------- FIFO
    always_comb begin
        lvl_nxt = level;
        if (push && !pop)
            lvl_nxt = level + LVL_W'(1);
        else if (pop && !push)
            lvl_nxt = level - LVL_W'(1);
    end

    always_ff @(posedge CLOCK) begin
        if (push)
            mem[wr_ptr] <= bus.WORD_DATA;
    end

    // Depth is a power of two, so the pointers wrap on their own.
    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            level          <= '0;
            bus.WORD_READY <= 1'b1;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            level          <= lvl_nxt;
            bus.WORD_READY <= (lvl_nxt != LVL_W'(FIFO_DEPTH));
        end
    end

    // ---------------------------------------------------------------- FSM
    // The LOAD cycle already drives SCL low, so the first low phase starts
    // its divider at 1 to keep every bit exactly CLK_DIV cycles long.
    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            state           <= IDLE;
            cfg_q           <= 1'b0;
            had_word        <= 1'b0;
            shreg           <= '0;
            bit_cnt         <= '0;
            div_cnt         <= '0;
            bus.CONFIG_DONE <= 1'b0;
            bus.CFG_SCL     <= 1'b0;
            bus.CFG_SDA     <= 1'b0;
            bus.CFG_OE      <= 1'b0;
            bus.WORDS_SENT  <= '0;
        end else begin
            cfg_q           <= bus.CONFIG_EN;
            bus.CONFIG_DONE <= 1'b0;
            bus.WORDS_SENT  <= bus.WORDS_SENT + 16'(sent_inc);
            case (state)
                IDLE: begin
                    if (cfg_rise && bus.ENABLE) begin
                        had_word <= (level != '0);
                        state    <= (level != '0) ? LOAD : DONE;
                    end
                end
                LOAD: begin
                    shreg       <= mem[rd_ptr];
                    bus.CFG_SDA <= mem[rd_ptr][WORD_W-1];
                    bus.CFG_OE  <= 1'b1;
                    bus.CFG_SCL <= 1'b0;
                    bit_cnt     <= '0;
                    div_cnt     <= (HALF == 1) ? DIV_W'(0) : DIV_W'(1);
                    state       <= (HALF == 1) ? SHIFT_HI : SHIFT_LO;
                end
                SHIFT_LO: begin
                    bus.CFG_SCL <= 1'b0;
                    if (div_cnt == '0)
                        bus.CFG_SDA <= shreg[WORD_W-1];
                    if (div_cnt == DIV_W'(HALF - 1)) begin
                        div_cnt <= '0;
                        state   <= SHIFT_HI;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                SHIFT_HI: begin
                    bus.CFG_SCL <= 1'b1;
                    if (div_cnt == DIV_W'(HALF - 1)) begin
                        div_cnt <= '0;
                        if (bit_cnt == BIT_W'(WORD_W - 1)) begin
                            state <= DONE;
                        end else begin
                            shreg   <= shreg << 1;
                            bit_cnt <= bit_cnt + BIT_W'(1);
                            state   <= SHIFT_LO;
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                DONE: begin
                    bus.CONFIG_DONE <= 1'b1;
                    bus.CFG_OE      <= 1'b0;
                    bus.CFG_SCL     <= 1'b0;
                    bus.CFG_SDA     <= 1'b0;
                    state           <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_config_sequencer.sv
// Directed bench for config_sequencer: a queue/timestamp model of the window
// protocol is compared every cycle, plus hand-computed literal expectations.
module tb_config_sequencer;
    localparam int W     = 16;
    localparam int D     = 8;
    localparam int DEPTH = 4;
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic CLOCK_tb = 1'b0;
    logic RESET_N_tb;
    always #5 CLOCK_tb = ~CLOCK_tb;

    config_sequencer_if #(.WORD_W(W), .FIFO_DEPTH(DEPTH)) ifc();

    config_sequencer #(.WORD_W(W), .CLK_DIV(D), .FIFO_DEPTH(DEPTH)) dut (
        .CLOCK   (CLOCK_tb),
        .RESET_N (RESET_N_tb),
        .bus     (ifc.slave)
    );

    int vectors = 0;
    int miscompares = 0;

    // model state: words waiting, sent count, and the active window timestamp
    logic [W-1:0] m_q[$];
    logic [W-1:0] m_word;
    logic [15:0]  m_sent;
    bit           m_act, m_had, m_valid, m_prev, m_rise, m_acc;
    int           m_k, m_end, cyc, t0;
    bit           preload_req = 1'b0;

    initial begin
        m_valid = 1'b0; m_act = 1'b0; m_prev = 1'b0; m_had = 1'b0;
        cyc = 0; t0 = -100000; m_k = 0; m_end = 0; m_sent = '0; m_word = '0;
        forever begin
            @(posedge CLOCK_tb);
            cyc++;
            if (!RESET_N_tb) begin
                m_q.delete();
                m_sent  = '0;
                m_act   = 1'b0;
                m_prev  = 1'b0;
                m_valid = 1'b1;
            end else if (m_valid) begin
                m_rise = ifc.CONFIG_EN && !m_prev;
                m_prev = ifc.CONFIG_EN;
                m_acc  = ifc.WORD_VALID && (m_q.size() < DEPTH);
                if (preload_req) m_sent = 16'hFFFF;
                if (m_act) begin
                    if (m_k == m_end) m_act = 1'b0;
                    else begin
                        m_k++;
                        if (m_k == 1 && m_had) void'(m_q.pop_front());
                        if (m_k == m_end && m_had) m_sent++;
                    end
                end
                if (!m_act && m_rise && ifc.ENABLE) begin
                    m_act = 1'b1;
                    m_k   = 0;
                    t0    = cyc;
                    m_had = (m_q.size() > 0);
                    m_end = m_had ? 1 + W * D : 1;
                    if (m_had) m_word = m_q[0];
                end
                if (m_acc) m_q.push_back(ifc.WORD_DATA);
            end
        end
    end

    // compare + window monitor
    bit             e_oe, e_scl, e_sda, e_done, e_busy, prev_scl, oe_seen;
    logic [15:0]    e_sent;
    logic [24:0]    got_v, exp_v;
    logic [W-1:0]   rise_bits;
    int             rise_cnt, done_cnt, done_total, gap_bad, first_rise, done_k, last_rise, seen_t0;

    initial begin
        prev_scl = 1'b0; oe_seen = 1'b0; rise_bits = '0; rise_cnt = 0; done_cnt = 0;
        done_total = 0; gap_bad = 0; first_rise = -1; done_k = -1; last_rise = 0; seen_t0 = -100000;
        forever begin
            @(negedge CLOCK_tb);
            if (m_valid) begin
                e_oe = 0; e_scl = 0; e_sda = 0; e_done = 0; e_busy = 0;
                if (m_act) begin
                    e_busy = (m_k < m_end);
                    e_done = (m_k == m_end);
                    e_oe   = m_had && m_k >= 1 && m_k <= W * D;
                    if (e_oe) begin
                        e_scl = (((m_k - 1) / (D / 2)) % 2) == 1;
                        e_sda = m_word[W - 1 - (m_k - 1) / D];
                    end
                end
                e_sent = preload_req ? 16'hFFFF : m_sent;
                exp_v = {e_done, e_scl, e_sda, e_oe, e_busy, (m_q.size() < DEPTH),
                         LVL_W'(m_q.size()), e_sent};
                got_v = {ifc.CONFIG_DONE, ifc.CFG_SCL, ifc.CFG_SDA, ifc.CFG_OE, ifc.BUSY,
                         ifc.WORD_READY, ifc.FIFO_LEVEL, ifc.WORDS_SENT};
                vectors++;
                if (got_v !== exp_v) begin
                    miscompares++;
                    $display("FAIL cycle_check cyc=%0d got done/scl/sda/oe/busy/rdy/lvl/sent=%h required=%h",
                             cyc, got_v, exp_v);
                end
                if (t0 != seen_t0) begin
                    seen_t0 = t0; rise_cnt = 0; done_cnt = 0; gap_bad = 0;
                    first_rise = -1; done_k = -1; oe_seen = 1'b0;
                end
                if (ifc.CFG_OE) oe_seen = 1'b1;
                if (ifc.CFG_SCL && !prev_scl) begin
                    rise_bits = {rise_bits[W-2:0], ifc.CFG_SDA};
                    if (rise_cnt > 0 && (cyc - last_rise) != D) gap_bad++;
                    if (rise_cnt == 0) first_rise = cyc - t0;
                    last_rise = cyc;
                    rise_cnt++;
                end
                prev_scl = ifc.CFG_SCL;
                if (ifc.CONFIG_DONE) begin
                    done_cnt++; done_total++; done_k = cyc - t0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h required=%0h", name, got, exp);
        end
    endtask

    task automatic push(input logic [W-1:0] w);
        @(negedge CLOCK_tb);
        ifc.WORD_VALID = 1'b1;
        ifc.WORD_DATA  = w;
        @(negedge CLOCK_tb);
        ifc.WORD_VALID = 1'b0;
    endtask

    task automatic window(input int hi);
        @(negedge CLOCK_tb);
        ifc.CONFIG_EN = 1'b1;
        repeat (hi) @(negedge CLOCK_tb);
        ifc.CONFIG_EN = 1'b0;
    endtask

    task automatic wait_k(input int n);
        int guard = 0;
        while ((cyc - t0) < n && guard < 1000) begin
            @(negedge CLOCK_tb);
            guard++;
        end
        if (guard >= 1000) check("wait_bound", 32'(guard), 32'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d required finish", cyc);
        $fatal(1, "watchdog");
    end

    logic [W-1:0] words [5];
    int dt;

    initial begin
        words[0] = 16'h0001; words[1] = 16'h8000; words[2] = 16'hFFFF;
        words[3] = 16'h3C5A; words[4] = 16'hDEAD;
        RESET_N_tb = 1'b0;
        ifc.ENABLE = 1'b1; ifc.CONFIG_EN = 1'b0; ifc.WORD_VALID = 1'b0; ifc.WORD_DATA = '0;
        repeat (3) @(negedge CLOCK_tb);
        check("reset_outputs", 32'({ifc.CONFIG_DONE, ifc.CFG_SCL, ifc.CFG_SDA, ifc.CFG_OE,
                                   ifc.BUSY, ifc.WORD_READY}), 32'h01);
        check("reset_level", 32'(ifc.FIFO_LEVEL), 32'd0);
        check("reset_sent", 32'(ifc.WORDS_SENT), 32'd0);
        RESET_N_tb = 1'b1;

        // single word A5C3
        push(16'hA5C3);
        window(3);
        wait_k(135);
        check("a5c3_bits", 32'(rise_bits), 32'b1010010111000011);
        check("a5c3_rises", 32'(rise_cnt), 32'd16);
        check("a5c3_gap", 32'(gap_bad), 32'd0);
        check("a5c3_first_rise", 32'(first_rise), 32'd5);
        check("a5c3_done_cycle", 32'(done_k), 32'd129);
        check("a5c3_done_count", 32'(done_cnt), 32'd1);
        check("a5c3_sent", 32'(ifc.WORDS_SENT), 32'd1);
        check("a5c3_level", 32'(ifc.FIFO_LEVEL), 32'd0);

        // empty skip
        window(3);
        wait_k(5);
        check("skip_done_cycle", 32'(done_k), 32'd1);
        check("skip_oe", 32'(oe_seen), 32'd0);
        check("skip_rises", 32'(rise_cnt), 32'd0);
        check("skip_sent", 32'(ifc.WORDS_SENT), 32'd1);

        // five back-to-back pushes into a 4-deep FIFO
        for (int i = 0; i < 5; i++) begin
            @(negedge CLOCK_tb);
            if (i == 3) check("ready_before_4th", 32'(ifc.WORD_READY), 32'd1);
            if (i == 4) check("ready_after_4th", 32'(ifc.WORD_READY), 32'd0);
            ifc.WORD_VALID = 1'b1;
            ifc.WORD_DATA  = words[i];
        end
        @(negedge CLOCK_tb);
        ifc.WORD_VALID = 1'b0;
        check("full_level", 32'(ifc.FIFO_LEVEL), 32'd4);
        for (int i = 0; i < 4; i++) begin
            window(3);
            wait_k(135);
            check("order_bits", 32'(rise_bits), 32'(words[i]));
            check("order_done", 32'(done_k), 32'd129);
        end
        window(3);
        wait_k(5);
        check("fifth_skip_done", 32'(done_k), 32'd1);
        check("fifth_skip_rises", 32'(rise_cnt), 32'd0);
        check("sent_after_four", 32'(ifc.WORDS_SENT), 32'd5);

        // ENABLE low ignores the window; ENABLE dropped mid-word does not
        dt = done_total;
        ifc.ENABLE = 1'b0;
        window(3);
        repeat (10) @(negedge CLOCK_tb);
        check("disabled_no_done", 32'(done_total), 32'(dt));
        check("disabled_busy", 32'(ifc.BUSY), 32'd0);
        ifc.ENABLE = 1'b1;
        push(16'h1234);
        window(3);
        wait_k(40);
        ifc.ENABLE = 1'b0;
        wait_k(135);
        ifc.ENABLE = 1'b1;
        check("enable_drop_done", 32'(done_k), 32'd129);
        check("enable_drop_bits", 32'(rise_bits), 32'h1234);

        // second rise mid-word is dropped
        push(16'h00FF);
        window(3);
        wait_k(60);
        ifc.CONFIG_EN = 1'b1;
        repeat (2) @(negedge CLOCK_tb);
        ifc.CONFIG_EN = 1'b0;
        wait_k(135);
        check("rerise_done_count", 32'(done_cnt), 32'd1);
        check("rerise_done_cycle", 32'(done_k), 32'd129);
        check("rerise_bits", 32'(rise_bits), 32'h00FF);

        // reset mid-word
        push(16'h5555);
        push(16'h6666);
        dt = done_total;
        window(3);
        wait_k(60);
        RESET_N_tb = 1'b0;
        @(negedge CLOCK_tb);
        check("midreset_level", 32'(ifc.FIFO_LEVEL), 32'd0);
        check("midreset_pins", 32'({ifc.CFG_OE, ifc.CFG_SCL, ifc.CFG_SDA, ifc.BUSY}), 32'd0);
        check("midreset_sent", 32'(ifc.WORDS_SENT), 32'd0);
        RESET_N_tb = 1'b1;
        repeat (140) @(negedge CLOCK_tb);
        check("midreset_no_done", 32'(done_total), 32'(dt));

        // preload WORDS_SENT to 0xFFFF, then push during the LOAD pop
        @(posedge CLOCK_tb); #1;
        force ifc.WORDS_SENT = 16'hFFFF;
        preload_req = 1'b1;
        @(posedge CLOCK_tb); #1;
        release ifc.WORDS_SENT;
        preload_req = 1'b0;
        push(16'hC001);
        push(16'hC002);
        ifc.CONFIG_EN = 1'b1;
        @(negedge CLOCK_tb);
        ifc.WORD_VALID = 1'b1;
        ifc.WORD_DATA  = 16'hC003;
        @(negedge CLOCK_tb);
        ifc.WORD_VALID = 1'b0;
        ifc.CONFIG_EN  = 1'b0;
        check("pushpop_level", 32'(ifc.FIFO_LEVEL), 32'd2);
        wait_k(135);
        check("wrap_sent", 32'(ifc.WORDS_SENT), 32'd0);
        check("wrap_bits", 32'(rise_bits), 32'hC001);

        repeat (3) @(negedge CLOCK_tb);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
